// File: rtl/fir_tdm_param.sv
// Time-multiplexed FIR filter: one shared MAC walks NTAPS taps per accepted
// sample, then rounds, saturates and presents the result for one cycle.
//
// Handshake: a sample is accepted at a rising edge where sample_valid=1 and
// busy=0. busy is 1 from the cycle after the accept through the DONE cycle.
// Any sample_valid seen while busy=1 is discarded and latches drop_flag.
// out_valid is a one-cycle pulse. out_data keeps its value until the next result.
module fir_tdm_param #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int NTAPS     = 15,
    parameter int ACC_W     = 40,
    parameter int OUT_SHIFT = 15,
    localparam int AW       = $clog2(NTAPS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_in,
    output logic                     busy,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     sat_flag,
    output logic                     drop_flag,
    output logic [1:0]               dbg_state
);

    localparam int PW = DATA_W + COEF_W;
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (OUT_SHIFT - 1);
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W:0] MINV = -MAXV - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] delay_q [NTAPS];
    logic signed [COEF_W-1:0] coef_q  [NTAPS];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [AW-1:0]            k_q, k_d;
    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_data_q;
    logic                     sat_q, drop_q;

    logic                     accept;
    logic signed [DATA_W-1:0] sel_d;
    logic signed [COEF_W-1:0] sel_c;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W:0]    rnd;
    logic signed [ACC_W:0]    shifted;
    logic signed [DATA_W-1:0] res;
    logic                     sat_now;

    assign accept    = sample_valid && (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_q;
    assign drop_flag = drop_q;
    assign dbg_state = state_q;

    // Select the tap addressed by k and form the full-width signed product
    always_comb begin
        sel_d = '0;
        sel_c = '0;
        for (int i = 0; i < NTAPS; i++) begin
            if (k_q == AW'(i)) begin
                sel_d = delay_q[i];
                sel_c = coef_q[i];
            end
        end
        prod = PW'(sel_d) * PW'(sel_c);
    end

    // Round half-up, arithmetic shift, clamp to the output range
    always_comb begin
        rnd     = {acc_q[ACC_W-1], acc_q} + HALF;
        shifted = rnd >>> OUT_SHIFT;
        sat_now = 1'b0;
        res     = shifted[DATA_W-1:0];
        if (shifted > MAXV) begin
            res     = MAXV[DATA_W-1:0];
            sat_now = 1'b1;
        end else if (shifted < MINV) begin
            res     = MINV[DATA_W-1:0];
            sat_now = 1'b1;
        end
    end

    // FSM next state, accumulator and tap counter
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + {{(ACC_W - PW){prod[PW-1]}}, prod};
                k_d   = k_q + AW'(1);
                if (k_q == AW'(NTAPS - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath registers and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            out_valid_q <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                out_data_q <= res;
                if (sat_now) begin
                    sat_q <= 1'b1;
                end
            end
            if (sample_valid && state_q != S_IDLE) begin
                drop_q <= 1'b1;
            end
        end
    end

    // Delay line shifts on accept; coefficients load only while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= '0;
            end
        end else begin
            if (accept) begin
                delay_q[0] <= sample_in;
                for (int i = 1; i < NTAPS; i++) begin
                    delay_q[i] <= delay_q[i-1];
                end
            end
            if (coef_we && state_q == S_IDLE) begin
                for (int i = 0; i < NTAPS; i++) begin
                    if (coef_addr == AW'(i)) begin
                        coef_q[i] <= coef_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_tdm_param.sv
// Directed bench for fir_tdm_param at default parameters.
module tb_fir_tdm_param;

  localparam int W = 16;

  logic                clk;
  logic                reset;
  logic                sample_valid;
  logic signed [15:0]  sample_in;
  logic                busy;
  logic                coef_we;
  logic [3:0]          coef_addr;
  logic signed [15:0]  coef_data;
  logic                out_valid;
  logic signed [15:0]  out_data;
  logic                sat_flag;
  logic                drop_flag;
  logic [1:0]          dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int out_count = 0;
  logic [W-1:0] exp_q[$];

  int coefs [15] = '{0, 194, 0, -111, 0, 127, 0, 866, 0, 127, 0, -111, 0, 194, 0};

  fir_tdm_param dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .busy         (busy),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .sat_flag     (sat_flag),
    .drop_flag    (drop_flag),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // scoreboard: every out_valid pulse must match the head of exp_q
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      out_count++;
      if (exp_q.size() == 0) check("spurious_out_valid", 1, 0);
      else check("out_data", int'(out_data), int'($signed(exp_q.pop_front())));
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_valid = 1'b0;
    coef_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_coef(input int addr, input int val);
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = 4'(addr);
    coef_data = 16'(val);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic load_coefs();
    for (int i = 0; i < 15; i++) write_coef(i, coefs[i]);
  endtask

  task automatic load_all(input int val);
    for (int i = 0; i < 15; i++) write_coef(i, val);
  endtask

  task automatic send_sample(input int v, input int exp_v);
    exp_q.push_back(W'(exp_v));
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in = 16'(v);
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (17) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_sat_flag"}, int'(sat_flag), 0);
    check({tag, "_drop_flag"}, int'(drop_flag), 0);
  endtask

  initial begin
    int cnt0;
    reset = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;

    // reset state
    do_reset();
    check_zero_outputs("reset");

    // impulse response
    load_coefs();
    cnt0 = out_count;
    for (int n = 0; n < 15; n++) send_sample((n == 0) ? 32767 : 0, coefs[n]);
    check("impulse_count", out_count - cnt0, 15);
    check("impulse_sat_flag", int'(sat_flag), 0);
    check("impulse_pending", exp_q.size(), 0);

    // latency: accept at edge t, busy after edges t..t+15, out_valid after t+16 only
    exp_q.push_back(W'(0));
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in = 16'sd0;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    check("lat_busy_0", int'(busy), 1);
    check("lat_ov_0", int'(out_valid), 0);
    for (int i = 1; i < 20; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat_busy_%0d", i), int'(busy), (i <= 15) ? 1 : 0);
      check($sformatf("lat_ov_%0d", i), int'(out_valid), (i == 16) ? 1 : 0);
    end
    check("lat_pending", exp_q.size(), 0);

    // positive saturation: first output 32767*32767 rounds to 32766 unsaturated
    do_reset();
    load_all(32767);
    send_sample(32767, 32766);
    check("satp_first_flag", int'(sat_flag), 0);
    for (int n = 1; n < 15; n++) send_sample(32767, 32767);
    check("satp_final", int'(out_data), 32767);
    check("satp_flag", int'(sat_flag), 1);

    // negative saturation from a clean delay line
    do_reset();
    load_all(32767);
    send_sample(-32768, -32767);
    check("satn_first_flag", int'(sat_flag), 0);
    for (int n = 1; n < 15; n++) send_sample(-32768, -32768);
    check("satn_final", int'(out_data), -32768);
    check("satn_flag", int'(sat_flag), 1);

    // drop: second strobe 3 cycles after accept is discarded
    do_reset();
    load_coefs();
    cnt0 = out_count;
    exp_q.push_back(W'(0));
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in = 16'sd32767;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    sample_valid = 1'b1;
    sample_in = 16'sd12345;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("drop_flag", int'(drop_flag), 1);
    check("drop_count", out_count - cnt0, 1);
    send_sample(0, 194);
    send_sample(0, 0);
    send_sample(0, -111);
    check("drop_pending", exp_q.size(), 0);

    // reset mid-MAC: no output for the aborted sample, coefficients cleared
    cnt0 = out_count;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in = 16'sd32767;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    do_reset();
    check_zero_outputs("midmac");
    repeat (20) @(negedge clk);
    check("midmac_count", out_count - cnt0, 0);
    for (int n = 0; n < 15; n++) send_sample((n == 0) ? 32767 : 0, 0);
    check("midmac_zero_count", out_count - cnt0, 15);

    // coefficient write while busy is ignored
    do_reset();
    load_coefs();
    exp_q.push_back(W'(0));
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in = 16'sd32767;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    coef_we = 1'b1;
    coef_addr = 4'd1;
    coef_data = 16'sd1000;
    @(negedge clk);
    coef_we = 1'b0;
    repeat (13) @(negedge clk);
    send_sample(0, 194);
    check("busywr_pending", exp_q.size(), 0);
    check("busywr_drop_flag", int'(drop_flag), 0);

    // write and accept on the same idle edge: new coefficient used
    do_reset();
    exp_q.push_back(W'(500));
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = 4'd0;
    coef_data = 16'sd500;
    sample_valid = 1'b1;
    sample_in = 16'sd32767;
    @(negedge clk);
    coef_we = 1'b0;
    sample_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("samedge_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
